// File: rtl/serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_subtractor : bit-serial unsigned A-B, LSB first, start/done       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+

module half_subtractor (
   input  logic a,
   input  logic b,
   output logic diff,
   output logic borrow
);
   assign diff   = a ^ b;
   assign borrow = ~a & b;
endmodule

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] C_LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic             br_q, br_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic w_hs0_diff, w_hs0_borrow;
   logic w_step_diff, w_hs1_borrow;
   logic w_br_next;

   // One full-subtractor step: two half-subtractor stages joined by a borrow OR.
   half_subtractor u_hs0 (
      .a      (sa_q[0]),
      .b      (sb_q[0]),
      .diff   (w_hs0_diff),
      .borrow (w_hs0_borrow)
   );

   half_subtractor u_hs1 (
      .a      (w_hs0_diff),
      .b      (br_q),
      .diff   (w_step_diff),
      .borrow (w_hs1_borrow)
   );

   assign w_br_next = w_hs0_borrow | w_hs1_borrow;

   always_comb begin
      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      sr_d     = sr_q;
      br_d     = br_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;

      case (state_q)
         S_RUN: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            sr_d  = {w_step_diff, sr_q[WIDTH-1:1]};
            br_d  = w_br_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == C_LAST_CNT) begin
               diff_d   = {w_step_diff, sr_q[WIDTH-1:1]};
               borrow_d = w_br_next;
               state_d  = S_DONE;
            end
         end
         default: begin
            // IDLE and DONE both accept a new request, giving back-to-back issue.
            if (start) begin
               sa_d    = A;
               sb_d    = B;
               sr_d    = '0;
               br_d    = 1'b0;
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         sr_q     <= '0;
         br_q     <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         sr_q     <= sr_d;
         br_q     <= br_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_subtractor : directed + random checks at WIDTH 8, 2 and 16     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+

module tb_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        st [3];
   logic [15:0] ia [3];
   logic [15:0] ib [3];
   logic        bsy [3];
   logic        dn [3];
   logic        brw [3];
   logic [15:0] df [3];
   logic [7:0]  df8;
   logic [1:0]  df2;
   logic [15:0] df16;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(st[0]), .A(ia[0][7:0]), .B(ib[0][7:0]),
      .busy(bsy[0]), .done(dn[0]), .diff(df8), .borrow(brw[0]));

   serial_subtractor #(.WIDTH(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(st[1]), .A(ia[1][1:0]), .B(ib[1][1:0]),
      .busy(bsy[1]), .done(dn[1]), .diff(df2), .borrow(brw[1]));

   serial_subtractor #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .start(st[2]), .A(ia[2]), .B(ib[2]),
      .busy(bsy[2]), .done(dn[2]), .diff(df16), .borrow(brw[2]));

   assign df[0] = {8'h00, df8};
   assign df[1] = {14'h0, df2};
   assign df[2] = df16;

   function automatic int wid(input int i);
      return (i == 0) ? 8 : (i == 1) ? 2 : 16;
   endfunction

   // Transaction-level model: an accepted request yields (A-B) mod 2^W and A<B
   // exactly W edges later; busy while that countdown is nonzero.
   int          m_rem    [3];
   logic [15:0] m_res    [3];
   logic        m_bor    [3];
   logic [15:0] m_diff   [3];
   logic        m_borrow [3];
   logic        m_done   [3];
   logic        m_busy   [3];

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         logic [15:0] mask;
         mask = 16'((32'h1 << wid(i)) - 1);
         if (rst) begin
            m_rem[i] = 0; m_done[i] = 1'b0; m_busy[i] = 1'b0;
            m_diff[i] = '0; m_borrow[i] = 1'b0; m_res[i] = '0; m_bor[i] = 1'b0;
         end else begin
            m_done[i] = 1'b0;
            if (m_rem[i] > 0) begin
               m_rem[i] = m_rem[i] - 1;
               if (m_rem[i] == 0) begin
                  m_done[i]   = 1'b1;
                  m_diff[i]   = m_res[i];
                  m_borrow[i] = m_bor[i];
               end
            end else if (st[i]) begin
               m_rem[i] = wid(i);
               m_res[i] = (ia[i] - ib[i]) & mask;
               m_bor[i] = (ia[i] < ib[i]);
            end
            m_busy[i] = (m_rem[i] > 0);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("cycle_w%0d {busy,done,borrow,diff}", wid(i)),
                {13'h0, bsy[i], dn[i], brw[i], df[i]},
                {13'h0, m_busy[i], m_done[i], m_borrow[i], m_diff[i]});
         end
      end
   end

   // Issues one request on DUT idx and waits for its done pulse; returns latency
   // in negedges after the accepting edge (W+1 expected), -1 on timeout.
   task automatic issue(input int idx, input logic [15:0] a, input logic [15:0] b,
                        output int lat);
      int n;
      @(negedge clk);
      ia[idx] = a; ib[idx] = b; st[idx] = 1'b1;
      @(negedge clk);
      st[idx] = 1'b0;
      n = 1;
      while (dn[idx] !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      lat = (dn[idx] === 1'b1) ? n : -1;
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_d, input logic exp_b);
      int lat;
      issue(0, {8'h0, a}, {8'h0, b}, lat);
      chk($sformatf("latency %0h-%0h", a, b), lat, 9);
      chk($sformatf("diff %0h-%0h", a, b), df8, exp_d);
      chk($sformatf("borrow %0h-%0h", a, b), brw[0], exp_b);
      chk($sformatf("model_diff %0h-%0h", a, b), m_diff[0], {8'h0, exp_d});
   endtask

   task automatic rand_ops(input int idx, input int n);
      int lat;
      logic [15:0] mask;
      mask = 16'((32'h1 << wid(idx)) - 1);
      for (int k = 0; k < n; k++) begin
         issue(idx, 16'($urandom) & mask, 16'($urandom) & mask, lat);
         if (lat < 0) chk($sformatf("rand_timeout_w%0d", wid(idx)), 0, 1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   int dones;
   int lat;

   initial begin
      for (int i = 0; i < 3; i++) begin
         st[i] = 1'b0; ia[i] = '0; ib[i] = '0;
      end
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      chk("reset {busy,done,borrow,diff}", {bsy[0], dn[0], brw[0], df8}, 11'h000);
      rst = 1'b0;

      run_op(8'h5A, 8'h3C, 8'h1E, 1'b0);
      run_op(8'h3C, 8'h5A, 8'hE2, 1'b1);
      run_op(8'h00, 8'h01, 8'hFF, 1'b1);
      run_op(8'hFF, 8'hFF, 8'h00, 1'b0);

      // A start raised mid-run must be ignored.
      @(negedge clk);
      ia[0] = 16'h10; ib[0] = 16'h01; st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      ia[0] = 16'hAA; ib[0] = 16'h55; st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      dones = 0;
      repeat (25) begin
         @(negedge clk);
         if (dn[0] === 1'b1) begin
            dones++;
            chk("ignored_start diff", df8, 8'h0F);
            chk("ignored_start borrow", brw[0], 1'b0);
         end
      end
      chk("ignored_start done count", dones, 1);

      // Start held high: one result every 9 cycles.
      @(negedge clk);
      ia[0] = 16'h80; ib[0] = 16'h7F; st[0] = 1'b1;
      begin
         int last, n, gaps;
         last = -1; n = 0; gaps = 0;
         while (gaps < 3 && n < 60) begin
            @(negedge clk);
            n++;
            if (dn[0] === 1'b1) begin
               chk("held diff", df8, 8'h01);
               if (last >= 0) begin
                  chk("held spacing", n - last, 9);
                  gaps++;
               end
               last = n;
            end
         end
         chk("held gaps seen", gaps, 3);
      end
      st[0] = 1'b0;
      repeat (12) @(negedge clk);

      // Reset mid-run aborts with no result update or done pulse.
      run_op(8'h5A, 8'h3C, 8'h1E, 1'b0);
      @(negedge clk);
      ia[0] = 16'h3C; ib[0] = 16'h5A; st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort {busy,done,borrow,diff}", {bsy[0], dn[0], brw[0], df8}, 11'h000);
      dones = 0;
      repeat (20) begin
         @(negedge clk);
         if (dn[0] === 1'b1) dones++;
      end
      chk("abort done count", dones, 0);

      fork
         rand_ops(0, 1000);
         rand_ops(1, 300);
         rand_ops(2, 300);
      join
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
